burst_comparator: RTL

Parametrised, clocked successor to the single-bit equality comparator: compares bursts of WIDTH-bit word pairs under a selectable relation (EQ/NE/LT/LE/GT/GE, signed or unsigned) and emits a registered per-word result. Over the burst it accumulates pass/fail statistics: failure count, index of the first failing pair, and an overall pass flag. It sits between two word streams, for example a DUT output and a golden model, and reports through a start/busy/done control interface.

---
 rtl/burst_comparator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/burst_comparator.sv
// Burst word comparator: evaluates x REL y per accepted pair and accumulates
// failure count, first failing index and an overall pass flag per burst.
module burst_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       mode,
    input  logic             sgn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             z,
    output logic             z_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] fail_cnt,
    output logic [LEN_W-1:0] first_fail
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [LEN_W-1:0] One     = LEN_W'(1);
    localparam logic [LEN_W-1:0] AllOnes = '1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       mode_q, mode_d;
    logic             sgn_q, sgn_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [LEN_W-1:0] first_fail_q, first_fail_d;
    logic             pass_q, pass_d;
    logic             z_q, z_d;
    logic             z_valid_q, z_valid_d;

    logic eq, lt, rel;

    always_comb begin
        eq = (x == y);
        if (sgn_q) begin
            lt = ($signed(x) < $signed(y));
        end else begin
            lt = (x < y);
        end
        case (mode_q)
            3'b001:  rel = ~eq;
            3'b010:  rel = lt;
            3'b011:  rel = lt | eq;
            3'b100:  rel = ~lt & ~eq;
            3'b101:  rel = ~lt;
            default: rel = eq;  // 000 and the unused codes 110/111
        endcase
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        mode_d       = mode_q;
        sgn_d        = sgn_q;
        idx_d        = idx_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        z_d          = z_q;
        z_valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d        = len;
                    mode_d       = mode;
                    sgn_d        = sgn;
                    idx_d        = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = AllOnes;
                    if (len == '0) begin
                        pass_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (in_valid) begin
                    z_d       = rel;
                    z_valid_d = 1'b1;
                    idx_d     = idx_q + One;
                    if (!rel) begin
                        fail_cnt_d = fail_cnt_q + One;
                        if (first_fail_q == AllOnes) begin
                            first_fail_d = idx_q;
                        end
                    end
                    if (idx_q == len_q - One) begin
                        // Final statistics must be visible alongside done.
                        pass_d  = (fail_cnt_d == '0);
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_q        <= '0;
            mode_q       <= '0;
            sgn_q        <= 1'b0;
            idx_q        <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= AllOnes;
            pass_q       <= 1'b0;
            z_q          <= 1'b0;
            z_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            sgn_q        <= sgn_d;
            idx_q        <= idx_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            z_q          <= z_d;
            z_valid_q    <= z_valid_d;
        end
    end

    assign in_ready   = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign fail_cnt   = fail_cnt_q;
    assign first_fail = first_fail_q;
    assign z          = z_q;
    assign z_valid    = z_valid_q;

endmodule
